// File: rtl/fifo_sync_fwft_gen2_if.sv
// rtl/fifo_sync_fwft_gen2_if.sv - write/read/status bundle for the show-ahead sync FIFO
interface fifo_sync_fwft_gen2_if #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 256,
    parameter int CW         = $clog2(DEPTH) + 1
);
    logic [DATA_WIDTH-1:0] din;
    logic                  wr_en;
    logic                  wr_last;
    logic                  wr_drop;
    logic                  rd_en;
    logic [CW-1:0]         af_thresh;
    logic [CW-1:0]         ae_thresh;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic [CW-1:0]         usedw;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output din, wr_en, wr_last, wr_drop, rd_en, af_thresh, ae_thresh,
        input  dout, dout_valid, usedw, full, empty, almost_full, almost_empty,
               overflow, underflow
    );

    modport slave (
        input  din, wr_en, wr_last, wr_drop, rd_en, af_thresh, ae_thresh,
        output dout, dout_valid, usedw, full, empty, almost_full, almost_empty,
               overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_fwft_gen2.sv
// rtl/fifo_sync_fwft_gen2.sv - single-clock FWFT FIFO on inferred RAM; packet-commit mode under FIFO_SYNC_FWFT_PKT_EN
module fifo_sync_fwft_gen2 #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 256,
    parameter int CW         = $clog2(DEPTH) + 1,
    parameter     RAM_STYLE  = "AUTO"
) (
    input logic                  clk,
    input logic                  rst,
    input logic                  clr,
    fifo_sync_fwft_gen2_if.slave bus
);
    localparam int            AW      = CW - 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE     = CW'(1);

    // Pointers carry one extra wrap bit; only the low AW bits address the RAM.
    logic [CW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         cm_ptr_q, cm_ptr_d;
    logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         occ_q, occ_d;
    logic [CW-1:0]         usedw_q, usedw_d;
    logic                  pf_valid_q, pf_valid_d;
    logic                  dout_valid_q, dout_valid_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic [DATA_WIDTH-1:0] pf_data_q;

    logic                  full_c;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  ovf_set;
    logic                  ram_avail;
    logic                  ram_rd;
    logic                  dout_load;
    logic [CW-1:0]         n_commit;
    logic [CW-1:0]         n_drop;
    logic [AW-1:0]         wr_addr;
    logic [AW-1:0]         rd_addr;

`ifdef FIFO_SYNC_FWFT_PKT_EN
    logic                  drop;
    logic                  commit;
`else
    logic                  unused_pkt;
    assign unused_pkt = ^{bus.wr_last, bus.wr_drop};
`endif

    assign wr_addr = wr_ptr_q[AW-1:0];
    assign rd_addr = rd_ptr_q[AW-1:0];

    generate
        if (RAM_STYLE == "AUTO") begin : g_ram_auto
            logic [DATA_WIDTH-1:0] mem_q [DEPTH];
            // RAM write port and registered read port feeding the prefetch stage
            always_ff @(posedge clk) begin
                if (wr_acc) mem_q[wr_addr] <= bus.din;
                if (ram_rd) pf_data_q <= mem_q[rd_addr];
            end
        end else begin : g_ram_hint
            (* ram_style = RAM_STYLE *) logic [DATA_WIDTH-1:0] mem_q [DEPTH];
            // Same RAM, carrying the caller's inference hint
            always_ff @(posedge clk) begin
                if (wr_acc) mem_q[wr_addr] <= bus.din;
                if (ram_rd) pf_data_q <= mem_q[rd_addr];
            end
        end
    endgenerate

    // Next-state: write/commit side, RAM -> prefetch -> dout pipeline, counters, sticky errors
    always_comb begin
        full_c = (occ_q == DEPTH_C);
        rd_acc = bus.rd_en & dout_valid_q;
`ifdef FIFO_SYNC_FWFT_PKT_EN
        drop     = bus.wr_drop;
        wr_acc   = bus.wr_en & ~full_c & ~drop;
        ovf_set  = bus.wr_en & full_c & ~drop;
        commit   = wr_acc & bus.wr_last;
        wr_ptr_d = drop ? cm_ptr_q : wr_ptr_q + CW'(wr_acc);
        cm_ptr_d = commit ? wr_ptr_q + ONE : cm_ptr_q;
        n_commit = commit ? (wr_ptr_q + ONE - cm_ptr_q) : '0;
        n_drop   = drop ? (wr_ptr_q - cm_ptr_q) : '0;
`else
        wr_acc   = bus.wr_en & ~full_c;
        ovf_set  = bus.wr_en & full_c;
        wr_ptr_d = wr_ptr_q + CW'(wr_acc);
        cm_ptr_d = wr_ptr_d;
        n_commit = CW'(wr_acc);
        n_drop   = '0;
`endif
        // The RAM read pointer never passes the commit pointer, so uncommitted
        // words stay invisible; prefetch refills in the same cycle it drains.
        ram_avail    = (cm_ptr_q != rd_ptr_q);
        dout_load    = pf_valid_q & (~dout_valid_q | rd_acc);
        ram_rd       = ram_avail & (~pf_valid_q | dout_load);
        rd_ptr_d     = rd_ptr_q + CW'(ram_rd);
        pf_valid_d   = ram_rd | (pf_valid_q & ~dout_load);
        dout_valid_d = dout_load | (dout_valid_q & ~rd_acc);
        dout_d       = dout_load ? pf_data_q : dout_q;
        occ_d        = occ_q + CW'(wr_acc) - CW'(rd_acc) - n_drop;
        usedw_d      = usedw_q + n_commit - CW'(rd_acc);
        ovf_d        = ovf_q | ovf_set;
        udf_d        = udf_q | (bus.rd_en & ~dout_valid_q);

        if (clr) begin
            wr_ptr_d     = '0;
            cm_ptr_d     = '0;
            rd_ptr_d     = '0;
            occ_d        = '0;
            usedw_d      = '0;
            pf_valid_d   = 1'b0;
            dout_valid_d = 1'b0;
            dout_d       = '0;
            ovf_d        = 1'b0;
            udf_d        = 1'b0;
        end
    end

    // State registers; rst clears everything immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            cm_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            usedw_q      <= '0;
            pf_valid_q   <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_q       <= '0;
            ovf_q        <= 1'b0;
            udf_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            cm_ptr_q     <= cm_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            usedw_q      <= usedw_d;
            pf_valid_q   <= pf_valid_d;
            dout_valid_q <= dout_valid_d;
            dout_q       <= dout_d;
            ovf_q        <= ovf_d;
            udf_q        <= udf_d;
        end
    end

    assign bus.dout         = dout_q;
    assign bus.dout_valid   = dout_valid_q;
    assign bus.usedw        = usedw_q;
    assign bus.full         = full_c;
    assign bus.empty        = ~dout_valid_q;
    assign bus.almost_full  = (usedw_q >= bus.af_thresh);
    assign bus.almost_empty = (usedw_q <= bus.ae_thresh);
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_fifo_sync_fwft_gen2.sv
// tb/tb_fifo_sync_fwft_gen2.sv - randomized scoreboard bench for fifo_sync_fwft_gen2
module tb_fifo_sync_fwft_gen2;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef FIFO_SYNC_FWFT_PKT_EN
    localparam bit PKT = 1'b1;
`else
    localparam bit PKT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    fifo_sync_fwft_gen2_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    fifo_sync_fwft_gen2 #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: committed words in order with the cycle they become
    // visible (commit edge + 2), plus the not-yet-committed packet tail.
    typedef struct {
        logic [DW-1:0] d;
        int            rdy;
    } ent_t;
    ent_t          q[$];
    logic [DW-1:0] pend[$];
    int            cyc = 0;
    bit            m_ovf = 1'b0;
    bit            m_udf = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            pend.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            bit   vld;
            bit   full_m;
            ent_t e;
            vld = (q.size() > 0) && (q[0].rdy <= cyc);
            cyc++;
            if (clr) begin
                q.delete();
                pend.delete();
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end else begin
                full_m = (q.size() + pend.size()) == DEPTH;
                if (bus.rd_en && !vld) m_udf = 1'b1;
                if (bus.rd_en && vld) void'(q.pop_front());
                if (PKT && bus.wr_drop) begin
                    pend.delete();
                end else if (bus.wr_en) begin
                    if (full_m) begin
                        m_ovf = 1'b1;
                    end else begin
                        pend.push_back(bus.din);
                        if (!PKT || bus.wr_last) begin
                            while (pend.size() > 0) begin
                                e.d   = pend.pop_front();
                                e.rdy = cyc + 2;
                                q.push_back(e);
                            end
                        end
                    end
                end
            end
        end
    end

    // Monitor: compares every DUT output against the model once per cycle
    always @(negedge clk) begin
        if (mon_en) begin
            bit ev;
            int used;
            ev   = (q.size() > 0) && (q[0].rdy <= cyc);
            used = q.size();
            chk("dout_valid", int'(bus.dout_valid), int'(ev));
            chk("empty", int'(bus.empty), int'(!ev));
            if (ev) chk("dout", int'(bus.dout), int'(q[0].d));
            chk("usedw", int'(bus.usedw), used);
            chk("full", int'(bus.full), int'((q.size() + pend.size()) == DEPTH));
            chk("almost_full", int'(bus.almost_full), int'(used >= int'(bus.af_thresh)));
            chk("almost_empty", int'(bus.almost_empty), int'(used <= int'(bus.ae_thresh)));
            chk("overflow", int'(bus.overflow), int'(m_ovf));
            chk("underflow", int'(bus.underflow), int'(m_udf));
        end
    end

    task automatic drive(input bit w, input logic [DW-1:0] d, input bit last,
                         input bit drop, input bit r, input bit c);
        bus.wr_en   = w;
        bus.din     = d;
        bus.wr_last = last;
        bus.wr_drop = drop;
        bus.rd_en   = r;
        clr         = c;
        @(posedge clk);
        #2;
        bus.wr_en   = 1'b0;
        bus.wr_last = 1'b0;
        bus.wr_drop = 1'b0;
        bus.rd_en   = 1'b0;
        clr         = 1'b0;
    endtask

    initial begin
        bus.din       = '0;
        bus.wr_en     = 1'b0;
        bus.wr_last   = 1'b0;
        bus.wr_drop   = 1'b0;
        bus.rd_en     = 1'b0;
        bus.af_thresh = CW'(12);
        bus.ae_thresh = CW'(3);
        repeat (3) @(posedge clk);
        #2;
        rst    = 1'b0;
        mon_en = 1'b1;

        // reset state and threshold corner
        chk("rst_usedw", int'(bus.usedw), 0);
        chk("rst_empty", int'(bus.empty), 1);
        chk("rst_dout", int'(bus.dout), 0);
        chk("rst_almost_empty", int'(bus.almost_empty), 1);
        chk("rst_almost_full", int'(bus.almost_full), 0);
        bus.af_thresh = '0;
        #1;
        chk("rst_af_thresh0", int'(bus.almost_full), 1);
        bus.af_thresh = CW'(12);
        #1;

        // first-word latency
        drive(1, 8'hA5, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("lat_edge1_valid", int'(bus.dout_valid), 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("lat_edge2_valid", int'(bus.dout_valid), 1);
        chk("lat_edge2_dout", int'(bus.dout), 'hA5);
        drive(0, 0, 0, 0, 1, 0);
        chk("lat_edge3_valid", int'(bus.dout_valid), 0);
        chk("lat_edge3_usedw", int'(bus.usedw), 0);

        // fill to full, overflow, drain, then underflow
        for (int i = 0; i < DEPTH; i++) drive(1, DW'(i), 1, 0, 0, 0);
        chk("fill_full", int'(bus.full), 1);
        chk("fill_usedw", int'(bus.usedw), DEPTH);
        drive(1, 8'hEE, 1, 0, 0, 0);
        chk("fill_overflow", int'(bus.overflow), 1);
        for (int i = 0; i < DEPTH; i++) drive(0, 0, 0, 0, 1, 0);
        chk("drain_underflow", int'(bus.underflow), 0);
        chk("drain_usedw", int'(bus.usedw), 0);
        drive(0, 0, 0, 0, 1, 0);
        chk("empty_read_underflow", int'(bus.underflow), 1);
        chk("empty_read_dout", int'(bus.dout), DEPTH - 1);

        // almost flags around the thresholds
        drive(0, 0, 0, 0, 0, 1);
        for (int k = 1; k <= 13; k++) begin
            drive(1, DW'(k), 1, 0, 0, 0);
            chk("thr_almost_full", int'(bus.almost_full), int'(k >= 12));
            chk("thr_almost_empty", int'(bus.almost_empty), int'(k <= 3));
        end

        // streaming through pointer wrap
        drive(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 100; i++) drive(1, DW'(i), 1, 0, 1, 0);
        repeat (3) drive(0, 0, 0, 0, 1, 0);

        // asynchronous reset mid-operation
        for (int i = 0; i < 9; i++) drive(1, DW'(8'h30 + i), 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        chk("arst_usedw", int'(bus.usedw), 0);
        chk("arst_valid", int'(bus.dout_valid), 0);
        chk("arst_dout", int'(bus.dout), 0);
        chk("arst_overflow", int'(bus.overflow), 0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        // synchronous flush
        for (int i = 0; i < 9; i++) drive(1, DW'(8'h60 + i), 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1);
        chk("clr_usedw", int'(bus.usedw), 0);
        chk("clr_valid", int'(bus.dout_valid), 0);

`ifdef FIFO_SYNC_FWFT_PKT_EN
        // committed packet survives, dropped tail never appears
        for (int i = 0; i < 5; i++) drive(1, DW'(8'h80 + i), (i == 4), 0, 0, 0);
        chk("pkt_usedw_commit", int'(bus.usedw), 5);
        for (int i = 0; i < 3; i++) drive(1, DW'(8'h90 + i), 0, 0, 0, 0);
        chk("pkt_usedw_pending", int'(bus.usedw), 5);
        drive(0, 0, 0, 1, 0, 0);
        repeat (2) drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            chk("pkt_dout", int'(bus.dout), 'h80 + i);
            drive(0, 0, 0, 0, 1, 0);
        end
        chk("pkt_drained", int'(bus.dout_valid), 0);
`endif

        // randomized phases: write-heavy then read-heavy, with random thresholds
        for (int ph = 0; ph < 2; ph++) begin
            for (int n = 0; n < 800; n++) begin
                bit w, r, l, dr, c;
                w  = ($urandom_range(0, 99) < (ph == 0 ? 80 : 40));
                r  = ($urandom_range(0, 99) < (ph == 0 ? 35 : 75));
                l  = ($urandom_range(0, 3) == 0);
                dr = ($urandom_range(0, 39) == 0);
                c  = ($urandom_range(0, 299) == 0);
                if ($urandom_range(0, 19) == 0) bus.af_thresh = CW'($urandom_range(0, DEPTH));
                if ($urandom_range(0, 19) == 0) bus.ae_thresh = CW'($urandom_range(0, DEPTH));
                drive(w, DW'($urandom), l, dr, r, c);
            end
        end

        repeat (4) drive(0, 0, 0, 0, 0, 0);
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
